svc_uart_tx: RTL and testbench
==============================

// Module: svc_uart_tx
//
// PURPOSE
// - UART transmitter; serialises bytes onto txd, 8 data bits, LSB first.
// - Sits directly downstream of the print/string stages.
// - Consumes the utx_en / utx_data / utx_busy interface those stages drive.
// - Upstream asserts utx_en combinationally whenever utx_busy is low, so
//   utx_busy must rise on the cycle after an accept.
//
// PARAMETERS
// - CLOCK_FREQ  100_000_000  clk frequency in Hz
// - BAUD_RATE   115_200      line rate in bits/s
// - PARITY      0            0 = none, 1 = odd, 2 = even
// - STOP_BITS   1            1 or 2
//
// PORTS
// - clk       in   1  clock
// - rst_n     in   1  reset, synchronous, active-low
// - utx_en    in   1  byte strobe; accepted only when utx_busy is low
// - utx_data  in   8  byte to send; sampled on the accept edge
// - utx_busy  out  1  high while a frame is in progress (state != IDLE)
// - txd       out  1  serial line, idle high, registered output
//
// BEHAVIOUR
// - DIV = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE.
//   - Elaboration error if DIV < 2, PARITY > 2, or STOP_BITS is not 1 or 2.
// - Reset: state = IDLE, txd = 1, utx_busy = 0, baud counter = 0,
//   shift register = 0.
// - Accept = utx_en && state == IDLE.
//   - Latch utx_data into the shift register and restart the baud counter.
//   - Next edge: state = START, txd = 0, utx_busy = 1.
// - utx_en while busy: ignored; no queueing, no effect on the current frame.
// - utx_data is don't-care except on the accept edge.
// - Each bit is held exactly DIV clocks.
//   - Baud counter counts 0..DIV-1; tick = (cnt == DIV-1).
//   - Counter wraps to 0 on tick.
// - State machine, one txd value per state; states advance on tick:
//   - START:   txd = 0; on tick -> DATA with bit index = 0.
//   - DATA:    txd = shift[0]; on tick shift right and increment bit index.
//     - Index 7 on tick -> PARITY if PARITY != 0, else STOP.
//   - PARITY:  txd = ^data for even, ~^data for odd.
//     - Parity value is computed from the latched byte at accept.
//     - On tick -> STOP.
//   - STOP:    txd = 1 for STOP_BITS * DIV clocks (a stop counter counts
//     stop bits), then -> IDLE.
//   - IDLE:    txd = 1.
// - Frame length = (1 + 8 + (PARITY != 0) + STOP_BITS) * DIV clocks, counted
//   from the first txd low edge.
// - Back-to-back: utx_busy falls on the edge entering IDLE. An accept in that
//   IDLE cycle gives exactly 1 extra idle clock between frames, so the
//   per-byte period is frame length + 1.
// - Reset mid-frame: next edge txd = 1, utx_busy = 0, the frame is abandoned,
//   and no partial byte is resumed.
// - No glitches on txd: it is driven from a flop, never from combinational
//   state decode.
//
// STRUCTURE
// - Package svc_uart_pkg holds:
//   - the state enum (IDLE, START, DATA, PARITY, STOP);
//   - parity constants (SVC_UART_PARITY_NONE/ODD/EVEN);
//   - function svc_uart_div(clock_freq, baud).
//   - The RX block reuses all of these.
// - Sub-module svc_uart_baud: baud counter with a restart input and a tick
//   output, parameter DIV. Shared with the future RX for bit timing.
// - FSM, shift register, bit/stop counters and the txd flop are all in this
//   module.
//
// TESTING (CLOCK_FREQ = 10, BAUD_RATE = 1 → DIV = 10 unless stated)
// - 0x55, PARITY = 0, STOP_BITS = 1:
//   - txd = 0,1,0,1,0,1,0,1,0,1, each held 10 clocks.
//   - utx_busy high 100 clocks, rising 1 clock after the accept.
// - 0x07, PARITY = 2:
//   - Data bits 1,1,1,0,0,0,0,0, then parity bit = 1, then stop.
//   - Frame = 110 clocks.
//   - Same byte with PARITY = 1 gives parity bit = 0.
// - STOP_BITS = 2, 0xFF:
//   - txd low for exactly 10 clocks (start bit only), then high for 100.
//   - utx_busy high 110 clocks.
// - Drive utx_en continuously with 0xA3 then 0x3C:
//   - Two complete frames; start edges exactly 101 clocks apart.
// - Pulse utx_en with 0x00 at clocks 3, 20 and 50 of a frame:
//   - Ignored; the line carries only the original byte.
// - Assert rst_n = 0 for 1 clock during DATA bit 4:
//   - Next edge txd = 1, utx_busy = 0.
//   - A new byte is accepted the next cycle and framed correctly.

Source files
------------

// File: rtl/svc_uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and the baud divisor helper.
// Used by both the transmitter and the receiver.
package svc_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } svc_uart_state_e;

    localparam int SVC_UART_PARITY_NONE = 0;
    localparam int SVC_UART_PARITY_ODD  = 1;
    localparam int SVC_UART_PARITY_EVEN = 2;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int svc_uart_div(input int clock_freq, input int baud);
        return (clock_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/svc_uart_tx_if.sv
// Byte handshake between the print/string stages and the UART transmitter.
interface svc_uart_tx_if;

    logic       utx_en;
    logic [7:0] utx_data;
    logic       utx_busy;

    modport master (output utx_en, output utx_data, input utx_busy);
    modport slave  (input utx_en, input utx_data, output utx_busy);

endinterface

// File: rtl/svc_uart_baud.sv
// Bit-period timer: counts 0..DIV-1 and pulses tick on the last count.
// A restart pulse realigns the bit boundary to the current clock.
module svc_uart_baud #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/svc_uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// txd comes straight from a flop loaded with the value for the next state.
module svc_uart_tx
    import svc_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int PARITY     = SVC_UART_PARITY_NONE,
    parameter int STOP_BITS  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    svc_uart_tx_if.slave bus,
    output logic         txd
);

    localparam int DIV = svc_uart_div(CLOCK_FREQ, BAUD_RATE);

    if (DIV < 2 || PARITY < SVC_UART_PARITY_NONE || PARITY > SVC_UART_PARITY_EVEN ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("svc_uart_tx: DIV must be >= 2, PARITY 0..2 and STOP_BITS 1 or 2");
    end

    svc_uart_state_e state;
    svc_uart_state_e state_next;

    logic       accept;
    logic       tick;
    logic [7:0] shift;
    logic [7:0] shift_next;
    logic [2:0] bit_idx;
    logic       stop_cnt;
    logic       last_stop;
    logic       parity_bit;
    logic       txd_next;

    assign accept    = bus.utx_en && (state == ST_IDLE);
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign bus.utx_busy = (state != ST_IDLE);

    // Restarting on accept gives the start bit a full DIV clocks.
    svc_uart_baud #(
        .DIV(DIV)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(accept),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_START;
            ST_START:  if (tick) state_next = ST_DATA;
            ST_DATA:   if (tick && bit_idx == 3'd7)
                           state_next = (PARITY != SVC_UART_PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_next = ST_STOP;
            ST_STOP:   if (tick && last_stop) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The line value is decoded from the upcoming state so the flop lines up with it.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_next[0];
            ST_PARITY: txd_next = parity_bit;
            default:   txd_next = 1'b1;
        endcase
    end

    always_comb begin
        shift_next = shift;
        if (accept) begin
            shift_next = bus.utx_data;
        end else if (state == ST_DATA && tick) begin
            shift_next = {1'b0, shift[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift      <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            shift <= shift_next;
            if (accept) begin
                bit_idx    <= '0;
                stop_cnt   <= 1'b0;
                parity_bit <= (PARITY == SVC_UART_PARITY_EVEN) ? ^bus.utx_data : ~^bus.utx_data;
            end else if (tick) begin
                if (state == ST_DATA) bit_idx <= bit_idx + 3'd1;
                if (state == ST_STOP) stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txd <= 1'b1;
        end else begin
            txd <= txd_next;
        end
    end

endmodule

// File: tb/tb_svc_uart_tx.sv
// Bench for svc_uart_tx: four framing configurations share one stimulus stream
// and are compared cycle by cycle against a frame-level model of the line.
module tb_svc_uart_tx;

    localparam int DIV  = 10;
    localparam int NDUT = 4;
    localparam int MAXT = 300;
    localparam int PAR [NDUT] = '{0, 2, 1, 0};
    localparam int STB [NDUT] = '{1, 1, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       txd0, txd1, txd2, txd3;

    svc_uart_tx_if bus0 ();
    svc_uart_tx_if bus1 ();
    svc_uart_tx_if bus2 ();
    svc_uart_tx_if bus3 ();

    assign bus0.utx_en = en;  assign bus0.utx_data = data;
    assign bus1.utx_en = en;  assign bus1.utx_data = data;
    assign bus2.utx_en = en;  assign bus2.utx_data = data;
    assign bus3.utx_en = en;  assign bus3.utx_data = data;

    svc_uart_tx #(.CLOCK_FREQ(10), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(1))
        u_none1 (.clk(clk), .rst_n(rst_n), .bus(bus0), .txd(txd0));
    svc_uart_tx #(.CLOCK_FREQ(10), .BAUD_RATE(1), .PARITY(2), .STOP_BITS(1))
        u_even1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .txd(txd1));
    svc_uart_tx #(.CLOCK_FREQ(10), .BAUD_RATE(1), .PARITY(1), .STOP_BITS(1))
        u_odd1  (.clk(clk), .rst_n(rst_n), .bus(bus2), .txd(txd2));
    svc_uart_tx #(.CLOCK_FREQ(10), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(2))
        u_none2 (.clk(clk), .rst_n(rst_n), .bus(bus3), .txd(txd3));

    int checks;
    int errors;

    // Model: each DUT either idles or plays back a list of frame bits, DIV clocks each.
    bit          active [NDUT];
    int          pos    [NDUT];
    int          flen   [NDUT];
    logic [11:0] fbits  [NDUT];

    logic       sch_en   [MAXT];
    logic       sch_rst  [MAXT];
    logic [7:0] sch_data [MAXT];
    logic [3:0] samp     [MAXT];
    logic [3:0] esamp    [MAXT];
    logic [3:0] bsamp    [MAXT];
    logic [3:0] ebsamp   [MAXT];

    function automatic void model_load(input int i, input logic [7:0] d);
        int nb;
        fbits[i] = '1;
        fbits[i][0] = 1'b0;
        for (int k = 0; k < 8; k++) fbits[i][1 + k] = d[k];
        nb = 9;
        if (PAR[i] != 0) begin
            fbits[i][9] = (PAR[i] == 2) ? ^d : ~^d;
            nb = 10;
        end
        nb = nb + STB[i];
        flen[i]   = nb * DIV;
        pos[i]    = 0;
        active[i] = 1'b1;
    endfunction

    task automatic clear_sched();
        for (int t = 0; t < MAXT; t++) begin
            sch_en[t]   = 1'b0;
            sch_rst[t]  = 1'b1;
            sch_data[t] = 8'($urandom);
        end
    endtask

    task automatic apply_stimulus(input int n);
        for (int t = 0; t < n; t++) begin
            rst_n = sch_rst[t];
            en    = sch_en[t];
            data  = sch_data[t];
            @(posedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (!rst_n) begin
                    active[i] = 1'b0;
                end else if (active[i]) begin
                    pos[i] = pos[i] + 1;
                    if (pos[i] == flen[i]) active[i] = 1'b0;
                end else if (en) begin
                    model_load(i, data);
                end
            end
            #1;
            for (int i = 0; i < NDUT; i++) begin
                esamp[t][i]  = active[i] ? fbits[i][pos[i] / DIV] : 1'b1;
                ebsamp[t][i] = active[i];
            end
            samp[t]  = {txd3, txd2, txd1, txd0};
            bsamp[t] = {bus3.utx_busy, bus2.utx_busy, bus1.utx_busy, bus0.utx_busy};
        end
        en    = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic int count_busy(input int j, input int t0, input int t1);
        int c = 0;
        for (int t = t0; t < t1; t++) if (bsamp[t][j] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_level(input int j, input int t0, input int t1, input logic lvl);
        int c = 0;
        for (int t = t0; t < t1; t++) if (samp[t][j] === lvl) c++;
        return c;
    endfunction

    // Mid-bit sampling, like a receiver would, starting from the start-bit clock ts.
    function automatic logic [7:0] decode_byte(input int j, input int ts);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = samp[ts + DIV + DIV / 2 + k * DIV][j];
        return b;
    endfunction

    task automatic test_reset();
        clear_sched();
        for (int t = 0; t < 3; t++) begin
            sch_rst[t]  = 1'b0;
            sch_en[t]   = 1'b1;
            sch_data[t] = 8'hFF;
        end
        apply_stimulus(4);
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (samp[t] !== 4'b1111) begin
                errors++; $display("[TB] FAIL reset_txd t=%0d got=%b want=1111", t, samp[t]);
            end
            checks++;
            if (bsamp[t] !== 4'b0000) begin
                errors++; $display("[TB] FAIL reset_busy t=%0d got=%b want=0000", t, bsamp[t]);
            end
        end
    endtask

    task automatic test_pattern_55();
        logic [DIV-1:0] held;
        logic [DIV-1:0] want;
        clear_sched();
        sch_en[0] = 1'b1; sch_data[0] = 8'h55;
        apply_stimulus(130);
        for (int t = 0; t < 130; t++) begin
            checks++;
            if (samp[t] !== esamp[t]) begin
                errors++; $display("[TB] FAIL p55_txd t=%0d got=%b want=%b", t, samp[t], esamp[t]);
            end
            checks++;
            if (bsamp[t] !== ebsamp[t]) begin
                errors++; $display("[TB] FAIL p55_busy t=%0d got=%b want=%b", t, bsamp[t], ebsamp[t]);
            end
        end
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < DIV; c++) held[c] = samp[k * DIV + c][0];
            want = (k % 2 == 1) ? {DIV{1'b1}} : {DIV{1'b0}};
            checks++;
            if (held !== want) begin
                errors++; $display("[TB] FAIL p55_bit%0d got=%b want=%b", k, held, want);
            end
        end
        checks++;
        if (count_busy(0, 0, 130) != 100) begin
            errors++; $display("[TB] FAIL p55_busy_len got=%0d want=100", count_busy(0, 0, 130));
        end
    endtask

    task automatic test_parity_07();
        clear_sched();
        sch_en[0] = 1'b1; sch_data[0] = 8'h07;
        apply_stimulus(130);
        for (int t = 0; t < 130; t++) begin
            checks++;
            if (samp[t] !== esamp[t]) begin
                errors++; $display("[TB] FAIL par_txd t=%0d got=%b want=%b", t, samp[t], esamp[t]);
            end
            checks++;
            if (bsamp[t] !== ebsamp[t]) begin
                errors++; $display("[TB] FAIL par_busy t=%0d got=%b want=%b", t, bsamp[t], ebsamp[t]);
            end
        end
        checks++;
        if (decode_byte(1, 0) !== 8'h07) begin
            errors++; $display("[TB] FAIL par_data got=%h want=07", decode_byte(1, 0));
        end
        checks++;
        if (samp[95][1] !== 1'b1) begin
            errors++; $display("[TB] FAIL par_even_bit got=%b want=1", samp[95][1]);
        end
        checks++;
        if (samp[95][2] !== 1'b0) begin
            errors++; $display("[TB] FAIL par_odd_bit got=%b want=0", samp[95][2]);
        end
        checks++;
        if (count_busy(1, 0, 130) != 110) begin
            errors++; $display("[TB] FAIL par_frame_len got=%0d want=110", count_busy(1, 0, 130));
        end
    endtask

    task automatic test_stop2_ff();
        clear_sched();
        sch_en[0] = 1'b1; sch_data[0] = 8'hFF;
        apply_stimulus(130);
        for (int t = 0; t < 130; t++) begin
            checks++;
            if (samp[t] !== esamp[t]) begin
                errors++; $display("[TB] FAIL stop2_txd t=%0d got=%b want=%b", t, samp[t], esamp[t]);
            end
            checks++;
            if (bsamp[t] !== ebsamp[t]) begin
                errors++; $display("[TB] FAIL stop2_busy t=%0d got=%b want=%b", t, bsamp[t], ebsamp[t]);
            end
        end
        checks++;
        if (count_level(3, 0, 130, 1'b0) != 10) begin
            errors++; $display("[TB] FAIL stop2_low got=%0d want=10", count_level(3, 0, 130, 1'b0));
        end
        checks++;
        if (count_level(3, 10, 110, 1'b1) != 100) begin
            errors++; $display("[TB] FAIL stop2_high got=%0d want=100", count_level(3, 10, 110, 1'b1));
        end
        checks++;
        if (count_busy(3, 0, 130) != 110) begin
            errors++; $display("[TB] FAIL stop2_busy_len got=%0d want=110", count_busy(3, 0, 130));
        end
    endtask

    task automatic test_ignored();
        logic [7:0] b;
        b = 8'($urandom_range(1, 255));
        clear_sched();
        sch_en[0] = 1'b1; sch_data[0] = b;
        sch_en[3]  = 1'b1; sch_data[3]  = 8'h00;
        sch_en[20] = 1'b1; sch_data[20] = 8'h00;
        sch_en[50] = 1'b1; sch_data[50] = 8'h00;
        apply_stimulus(130);
        for (int t = 0; t < 130; t++) begin
            checks++;
            if (samp[t] !== esamp[t]) begin
                errors++; $display("[TB] FAIL ign_txd t=%0d got=%b want=%b", t, samp[t], esamp[t]);
            end
            checks++;
            if (bsamp[t] !== ebsamp[t]) begin
                errors++; $display("[TB] FAIL ign_busy t=%0d got=%b want=%b", t, bsamp[t], ebsamp[t]);
            end
        end
        checks++;
        if (decode_byte(0, 0) !== b) begin
            errors++; $display("[TB] FAIL ign_data got=%h want=%h", decode_byte(0, 0), b);
        end
        checks++;
        if (count_busy(0, 0, 130) != 100) begin
            errors++; $display("[TB] FAIL ign_busy_len got=%0d want=100", count_busy(0, 0, 130));
        end
    endtask

    // Start edges are falling edges seen outside a frame; after one, skip to its stop bit.
    task automatic find_starts(input int j, input int n, input int skip,
                               output int cnt, output int e0, output int e1);
        int   t;
        logic prev;
        cnt = 0; e0 = -1; e1 = -1; t = 0; prev = 1'b1;
        while (t < n) begin
            if (prev === 1'b1 && samp[t][j] === 1'b0) begin
                if (cnt == 0) e0 = t;
                if (cnt == 1) e1 = t;
                cnt++;
                t = t + skip;
                if (t < n) prev = samp[t][j];
            end else begin
                prev = samp[t][j];
            end
            t++;
        end
    endtask

    task automatic test_back_to_back();
        int cnt, e0, e1;
        clear_sched();
        for (int t = 0; t < 112; t++) begin
            sch_en[t]   = 1'b1;
            sch_data[t] = (t == 0) ? 8'hA3 : 8'h3C;
        end
        apply_stimulus(240);
        for (int t = 0; t < 240; t++) begin
            checks++;
            if (samp[t] !== esamp[t]) begin
                errors++; $display("[TB] FAIL b2b_txd t=%0d got=%b want=%b", t, samp[t], esamp[t]);
            end
            checks++;
            if (bsamp[t] !== ebsamp[t]) begin
                errors++; $display("[TB] FAIL b2b_busy t=%0d got=%b want=%b", t, bsamp[t], ebsamp[t]);
            end
        end
        find_starts(0, 240, 90, cnt, e0, e1);
        checks++;
        if (cnt != 2 || e1 - e0 != 101) begin
            errors++; $display("[TB] FAIL b2b_period0 got=%0d edges gap=%0d want=2 edges gap=101", cnt, e1 - e0);
        end
        find_starts(1, 240, 100, cnt, e0, e1);
        checks++;
        if (cnt != 2 || e1 - e0 != 111) begin
            errors++; $display("[TB] FAIL b2b_period1 got=%0d edges gap=%0d want=2 edges gap=111", cnt, e1 - e0);
        end
        checks++;
        if (decode_byte(0, 0) !== 8'hA3) begin
            errors++; $display("[TB] FAIL b2b_byte1 got=%h want=a3", decode_byte(0, 0));
        end
        checks++;
        if (decode_byte(0, 101) !== 8'h3C) begin
            errors++; $display("[TB] FAIL b2b_byte2 got=%h want=3c", decode_byte(0, 101));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b1, b2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        clear_sched();
        sch_en[0] = 1'b1; sch_data[0] = b1;
        sch_rst[53] = 1'b0;
        sch_en[54] = 1'b1; sch_data[54] = b2;
        apply_stimulus(184);
        for (int t = 0; t < 184; t++) begin
            checks++;
            if (samp[t] !== esamp[t]) begin
                errors++; $display("[TB] FAIL rmid_txd t=%0d got=%b want=%b", t, samp[t], esamp[t]);
            end
            checks++;
            if (bsamp[t] !== ebsamp[t]) begin
                errors++; $display("[TB] FAIL rmid_busy t=%0d got=%b want=%b", t, bsamp[t], ebsamp[t]);
            end
        end
        checks++;
        if (samp[53] !== 4'b1111 || bsamp[53] !== 4'b0000) begin
            errors++; $display("[TB] FAIL rmid_abort got=txd %b busy %b want=txd 1111 busy 0000", samp[53], bsamp[53]);
        end
        checks++;
        if (decode_byte(0, 54) !== b2) begin
            errors++; $display("[TB] FAIL rmid_new_byte got=%h want=%h", decode_byte(0, 54), b2);
        end
        checks++;
        if (count_busy(0, 54, 184) != 100) begin
            errors++; $display("[TB] FAIL rmid_busy_len got=%0d want=100", count_busy(0, 54, 184));
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            clear_sched();
            sch_en[0] = 1'b1;
            for (int t = 1; t < 150; t++) sch_en[t] = ($urandom_range(0, 3) == 0);
            apply_stimulus(150);
            for (int t = 0; t < 150; t++) begin
                checks++;
                if (samp[t] !== esamp[t]) begin
                    errors++; $display("[TB] FAIL rand%0d_txd t=%0d got=%b want=%b", r, t, samp[t], esamp[t]);
                end
                checks++;
                if (bsamp[t] !== ebsamp[t]) begin
                    errors++; $display("[TB] FAIL rand%0d_busy t=%0d got=%b want=%b", r, t, bsamp[t], ebsamp[t]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        data   = 8'h00;
        for (int i = 0; i < NDUT; i++) begin
            active[i] = 1'b0; pos[i] = 0; flen[i] = 0; fbits[i] = '1;
        end
        test_reset();
        test_pattern_55();
        test_parity_07();
        test_stop2_ff();
        test_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
